// File: rtl/cache_tag_lookup_pkg.sv
// Shared definitions for the cache tag/valid store: index widths, LRU flag sizing
// and the flush sequencer state encoding.
package cache_tag_lookup_pkg;

    typedef enum logic [0:0] {
        FLUSH_IDLE = 1'b0,
        FLUSH_RUN  = 1'b1
    } flush_state_e;

    // A single set or way still needs a one-bit index so the ports keep a legal width.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Tree pseudo-LRU needs one flag per internal node of the way tree.
    function automatic int lru_flag_bits(input int num_ways);
        return (num_ways > 1) ? num_ways - 1 : 1;
    endfunction

endpackage

// File: rtl/cache_tag_compare.sv
// Parallel tag compare across the ways of one set; the lowest matching way wins.
module cache_tag_compare
    import cache_tag_lookup_pkg::*;
#(
    parameter  int NUM_WAYS        = 4,
    parameter  int TAG_WIDTH       = 20,
    localparam int WAY_INDEX_WIDTH = idx_width(NUM_WAYS)
) (
    input  logic [NUM_WAYS-1:0][TAG_WIDTH-1:0] tags_i,
    input  logic [NUM_WAYS-1:0]                valid_i,
    input  logic [TAG_WIDTH-1:0]               tag_i,
    output logic [NUM_WAYS-1:0]                match_o,
    output logic                               hit_o,
    output logic [WAY_INDEX_WIDTH-1:0]         way_o
);

    always_comb begin
        match_o = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            match_o[w] = valid_i[w] && (tags_i[w] == tag_i);
        end
    end

    always_comb begin
        way_o = '0;
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (match_o[w]) way_o = WAY_INDEX_WIDTH'(w);
        end
    end

    assign hit_o = |match_o;

endmodule

// File: rtl/cache_tag_lookup.sv
// Tag/valid store and hit detection feeding the cache LRU block, plus a whole-cache
// flush sequencer that clears one set of valid bits per cycle.
//   state      | meaning
//   FLUSH_IDLE | lookups and fills accepted; flush_en starts a flush
//   FLUSH_RUN  | clearing set[cnt_q] each cycle; requests refused
module cache_tag_lookup
    import cache_tag_lookup_pkg::*;
#(
    parameter  int NUM_SETS        = 1,
    parameter  int NUM_WAYS        = 4,
    parameter  int TAG_WIDTH       = 20,
    localparam int SET_INDEX_WIDTH = idx_width(NUM_SETS),
    localparam int WAY_INDEX_WIDTH = idx_width(NUM_WAYS)
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       lookup_en_i,
    input  logic [SET_INDEX_WIDTH-1:0] lookup_set_i,
    input  logic [TAG_WIDTH-1:0]       lookup_tag_i,
    output logic                       lookup_valid_o,
    output logic                       lookup_hit_o,
    output logic [WAY_INDEX_WIDTH-1:0] lookup_way_o,
    input  logic                       fill_req_en_i,
    input  logic [SET_INDEX_WIDTH-1:0] fill_req_set_i,
    input  logic [TAG_WIDTH-1:0]       fill_req_tag_i,
    output logic                       fill_ready_o,
    output logic                       fill_done_o,
    output logic [WAY_INDEX_WIDTH-1:0] fill_done_way_o,
    input  logic                       flush_en_i,
    output logic                       flush_busy_o,
    output logic                       flush_done_o,
    output logic                       lru_fill_en_o,
    output logic [SET_INDEX_WIDTH-1:0] lru_fill_set_o,
    input  logic [WAY_INDEX_WIDTH-1:0] lru_fill_way_i,
    output logic                       lru_access_en_o,
    output logic [SET_INDEX_WIDTH-1:0] lru_access_set_o,
    output logic                       lru_update_en_o,
    output logic [WAY_INDEX_WIDTH-1:0] lru_update_way_o
);

    localparam logic [SET_INDEX_WIDTH-1:0] LAST_SET = SET_INDEX_WIDTH'(NUM_SETS - 1);

    logic [TAG_WIDTH-1:0] tag_q   [NUM_SETS][NUM_WAYS];
    logic [NUM_WAYS-1:0]  valid_q [NUM_SETS];

    flush_state_e               state_q;
    logic [SET_INDEX_WIDTH-1:0] cnt_q, cnt_d;
    logic                       busy_q, done_q;

    logic                       lk_vld_q, lk_acc_q, lk_fill_q;
    logic [SET_INDEX_WIDTH-1:0] lk_set_q;
    logic [TAG_WIDTH-1:0]       lk_tag_q;
    logic                       fl_vld_q;
    logic [SET_INDEX_WIDTH-1:0] fl_set_q;
    logic [TAG_WIDTH-1:0]       fl_tag_q;

    logic accept_ok, lk_acc, fill_acc;
    logic [SET_INDEX_WIDTH-1:0] lk_set, fl_set, flush_set;
    logic [WAY_INDEX_WIDTH-1:0] fill_way;

    logic [NUM_WAYS-1:0][TAG_WIDTH-1:0] cmp_tags;
    logic [NUM_WAYS-1:0]                cmp_valid, cmp_match;
    logic                               cmp_hit;
    logic [WAY_INDEX_WIDTH-1:0]         cmp_way;

    assign accept_ok = !busy_q && !reset_i;
    assign lk_acc    = lookup_en_i && accept_ok;
    assign fill_acc  = fill_req_en_i && accept_ok;

    // Degenerate single-set / single-way builds still carry a 1-bit index; pin it to 0.
    assign lk_set    = (NUM_SETS > 1) ? lk_set_q : '0;
    assign fl_set    = (NUM_SETS > 1) ? fl_set_q : '0;
    assign flush_set = (NUM_SETS > 1) ? cnt_q    : '0;
    assign fill_way  = (NUM_WAYS > 1) ? lru_fill_way_i : '0;

    assign cnt_d = cnt_q + SET_INDEX_WIDTH'(1);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= FLUSH_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                FLUSH_IDLE: begin
                    if (flush_en_i) begin
                        state_q <= FLUSH_RUN;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        done_q  <= (LAST_SET == '0);
                    end
                end
                FLUSH_RUN: begin
                    if (cnt_q == LAST_SET) begin
                        state_q <= FLUSH_IDLE;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b0;
                    end else begin
                        cnt_q  <= cnt_d;
                        done_q <= (cnt_d == LAST_SET);
                    end
                end
                default: state_q <= FLUSH_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            lk_vld_q  <= 1'b0;
            lk_acc_q  <= 1'b0;
            lk_fill_q <= 1'b0;
            lk_set_q  <= '0;
            lk_tag_q  <= '0;
            fl_vld_q  <= 1'b0;
            fl_set_q  <= '0;
            fl_tag_q  <= '0;
        end else begin
            lk_vld_q  <= lookup_en_i;
            lk_acc_q  <= lk_acc;
            lk_fill_q <= fill_acc;
            fl_vld_q  <= fill_acc;
            if (lk_acc) begin
                lk_set_q <= lookup_set_i;
                lk_tag_q <= lookup_tag_i;
            end
            if (fill_acc) begin
                fl_set_q <= fill_req_set_i;
                fl_tag_q <= fill_req_tag_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (fl_vld_q) tag_q[fl_set][fill_way] <= fl_tag_q;
    end

    // Flush clear is ordered after the fill so it wins on a same-set collision.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int s = 0; s < NUM_SETS; s++) valid_q[s] <= '0;
        end else begin
            if (fl_vld_q) valid_q[fl_set][fill_way] <= 1'b1;
            if (busy_q)   valid_q[flush_set]        <= '0;
        end
    end

    // A fill committing this cycle is forwarded into the compare of the same set.
    always_comb begin
        cmp_valid = valid_q[lk_set];
        for (int w = 0; w < NUM_WAYS; w++) cmp_tags[w] = tag_q[lk_set][w];
        if (fl_vld_q && (fl_set == lk_set)) begin
            cmp_tags[fill_way]  = fl_tag_q;
            cmp_valid[fill_way] = 1'b1;
        end
    end

    cache_tag_compare #(
        .NUM_WAYS  (NUM_WAYS),
        .TAG_WIDTH (TAG_WIDTH)
    ) u_compare (
        .tags_i  (cmp_tags),
        .valid_i (cmp_valid),
        .tag_i   (lk_tag_q),
        .match_o (cmp_match),
        .hit_o   (cmp_hit),
        .way_o   (cmp_way)
    );

    always_ff @(posedge clk_i) begin
        if (!reset_i && lk_acc_q) assert ($countones(cmp_match) <= 1);
    end

    assign lookup_valid_o   = lk_vld_q;
    assign lookup_hit_o     = lk_acc_q && cmp_hit;
    assign lookup_way_o     = lookup_hit_o ? cmp_way : '0;
    assign lru_update_en_o  = lookup_hit_o && !lk_fill_q;
    assign lru_update_way_o = lookup_way_o;

    assign lru_access_en_o  = lk_acc;
    assign lru_access_set_o = lookup_set_i;
    assign lru_fill_en_o    = fill_acc;
    assign lru_fill_set_o   = fill_req_set_i;

    assign fill_ready_o     = accept_ok;
    assign fill_done_o      = fl_vld_q;
    assign fill_done_way_o  = fl_vld_q ? lru_fill_way_i : '0;

    assign flush_busy_o     = busy_q;
    assign flush_done_o     = done_q;

endmodule
